rob_commit: RTL and testbench

- Retire stage directly downstream of the reorder buffer's will-clear outputs.
- Registers each commit group (up to COMMIT_WID entries per cycle) and updates the committed (architectural) rename table.
- Returns each superseded physical register to the freelist.
- Turns the oldest excepting entry into a backend squash, a drain wait, and a front-end redirect.

---
 rtl/rob_commit.sv | 191 +++++++++++++++++++
 tb/tb_rob_commit.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rob_commit.sv
// Retire stage behind the ROB: registers commit groups, updates the committed RAT,
// frees superseded physical registers and sequences exception squash/drain/redirect.
// Optional perf counters: define ROB_COMMIT_PERF_COUNTER_EN.
module rob_commit #(
    parameter int unsigned  COMMIT_WID   = 4,
    parameter int unsigned  ARCHREG_NUM  = 32,
    parameter int unsigned  PHYREG_NUM   = 64,
    parameter int unsigned  FLUSH_CYCLES = 3,
    parameter logic [63:0]  TRAP_VEC     = 64'h8000_0000,
    localparam int unsigned PREG_W       = $clog2(PHYREG_NUM)
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [COMMIT_WID-1:0]               i_commit_vld,
    input  logic [COMMIT_WID-1:0][4:0]          i_commit_ldst,
    input  logic [COMMIT_WID-1:0][PREG_W-1:0]   i_commit_pdst,
    input  logic [COMMIT_WID-1:0][PREG_W-1:0]   i_commit_old_pdst,
    input  logic [COMMIT_WID-1:0]               i_commit_rd_wen,
    input  logic [COMMIT_WID-1:0]               i_commit_except,
    input  logic [COMMIT_WID-1:0][63:0]         i_commit_pc,
    output logic [COMMIT_WID-1:0]               o_free_vld,
    output logic [COMMIT_WID-1:0][PREG_W-1:0]   o_free_preg,
    output logic                                o_squash,
    output logic                                o_busy,
    output logic [63:0]                         o_epc,
    output logic                                o_redirect_vld,
    output logic [63:0]                         o_redirect_pc,
    input  logic [4:0]                          i_rat_ridx,
    output logic [PREG_W-1:0]                   o_rat_rdata
`ifdef ROB_COMMIT_PERF_COUNTER_EN
    ,
    output logic [63:0]                         o_instret,
    output logic [31:0]                         o_except_cnt
`endif
);

    localparam int unsigned CNT_W   = 4;
    localparam logic [0:0]  S_IDLE  = 1'b0;
    localparam logic [0:0]  S_FLUSH = 1'b1;

    if (FLUSH_CYCLES < 1 || FLUSH_CYCLES > 15) begin : g_bad_flush_cycles
        $error("FLUSH_CYCLES must be within 1..15");
    end

    logic [0:0]                              state_q, state_d;
    logic [CNT_W-1:0]                        cnt_q, cnt_d;
    logic                                    accept;
    logic                                    blocked;
    logic                                    exc_hit;
    logic [63:0]                             exc_pc;
    logic [COMMIT_WID-1:0]                   free_sel;
    logic [COMMIT_WID-1:0]                   free_vld_q;
    logic [COMMIT_WID-1:0][PREG_W-1:0]       free_preg_q;
    logic [COMMIT_WID-1:0][4:0]              wr_ldst_q;
    logic [COMMIT_WID-1:0][PREG_W-1:0]       wr_pdst_q;
    logic                                    squash_q;
    logic [63:0]                             epc_q;
    logic                                    redirect_q;
    logic [63:0]                             redirect_pc_q;
    logic [PREG_W-1:0]                       rat_q [ARCHREG_NUM];
`ifdef ROB_COMMIT_PERF_COUNTER_EN
    logic [COMMIT_WID-1:0]                   retire;
    logic [COMMIT_WID-1:0]                   retire_q;
    logic [63:0]                             instret_q;
    logic [31:0]                             except_cnt_q;
`endif

    // Groups arriving in the squash cycle or during the drain are younger than the fault: drop them.
    assign accept = (state_q == S_IDLE) && !squash_q;

    // Truncate the group at the oldest excepting slot.
    always_comb begin
        blocked  = 1'b0;
        exc_hit  = 1'b0;
        exc_pc   = '0;
        free_sel = '0;
`ifdef ROB_COMMIT_PERF_COUNTER_EN
        retire   = '0;
`endif
        for (int unsigned i = 0; i < COMMIT_WID; i++) begin
            if (accept && i_commit_vld[i] && !blocked) begin
                if (i_commit_except[i]) begin
                    blocked = 1'b1;
                    exc_hit = 1'b1;
                    exc_pc  = i_commit_pc[i];
                end else begin
                    free_sel[i] = i_commit_rd_wen[i] && (i_commit_ldst[i] != 5'd0);
`ifdef ROB_COMMIT_PERF_COUNTER_EN
                    retire[i]   = 1'b1;
`endif
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (squash_q) begin
                    state_d = S_FLUSH;
                    cnt_d   = CNT_W'(FLUSH_CYCLES);
                end
            end
            S_FLUSH: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            free_vld_q    <= '0;
            free_preg_q   <= '0;
            wr_ldst_q     <= '0;
            wr_pdst_q     <= '0;
            squash_q      <= 1'b0;
            epc_q         <= '0;
            redirect_q    <= 1'b0;
            redirect_pc_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            free_vld_q <= free_sel;
            wr_ldst_q  <= i_commit_ldst;
            wr_pdst_q  <= i_commit_pdst;
            for (int unsigned i = 0; i < COMMIT_WID; i++) begin
                free_preg_q[i] <= free_sel[i] ? i_commit_old_pdst[i] : '0;
            end
            squash_q <= exc_hit;
            if (exc_hit) begin
                epc_q <= exc_pc;
            end
            // Redirect lands on the last drain cycle, FLUSH_CYCLES after the squash.
            redirect_q    <= (state_d == S_FLUSH) && (cnt_d == CNT_W'(1));
            redirect_pc_q <= ((state_d == S_FLUSH) && (cnt_d == CNT_W'(1))) ? TRAP_VEC : '0;
        end
    end

    // Ascending slot order makes the youngest writer of a shared ldst win.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned a = 0; a < ARCHREG_NUM; a++) begin
                rat_q[a] <= PREG_W'(a);
            end
        end else begin
            for (int unsigned i = 0; i < COMMIT_WID; i++) begin
                if (free_vld_q[i]) begin
                    rat_q[wr_ldst_q[i]] <= wr_pdst_q[i];
                end
            end
        end
    end

`ifdef ROB_COMMIT_PERF_COUNTER_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            retire_q     <= '0;
            instret_q    <= '0;
            except_cnt_q <= '0;
        end else begin
            retire_q     <= retire;
            instret_q    <= instret_q + 64'($countones(retire_q));
            except_cnt_q <= except_cnt_q + 32'(squash_q);
        end
    end

    assign o_instret    = instret_q;
    assign o_except_cnt = except_cnt_q;
`endif

    assign o_free_vld     = free_vld_q;
    assign o_free_preg    = free_preg_q;
    assign o_squash       = squash_q;
    assign o_busy         = (state_q == S_FLUSH);
    assign o_epc          = epc_q;
    assign o_redirect_vld = redirect_q;
    assign o_redirect_pc  = redirect_pc_q;
    assign o_rat_rdata    = rat_q[i_rat_ridx];

    a_no_commit_in_flush: assert property (@(posedge clk) disable iff (rst)
        (state_q == S_FLUSH) |-> (i_commit_vld == '0));

endmodule

// File: tb/tb_rob_commit.sv
// Bench for rob_commit: directed test-plan groups plus randomized traffic checked
// every cycle against a behavioural retire/RAT/flush model.
module tb_rob_commit;

    localparam int unsigned CW = 4;
    localparam int unsigned PW = 6;
    localparam int          F  = 3;
    localparam logic [63:0] TV = 64'h8000_0000;

    logic                    clk;
    logic                    rst;
    logic [CW-1:0]           i_commit_vld;
    logic [CW-1:0][4:0]      i_commit_ldst;
    logic [CW-1:0][PW-1:0]   i_commit_pdst;
    logic [CW-1:0][PW-1:0]   i_commit_old_pdst;
    logic [CW-1:0]           i_commit_rd_wen;
    logic [CW-1:0]           i_commit_except;
    logic [CW-1:0][63:0]     i_commit_pc;
    logic [CW-1:0]           o_free_vld;
    logic [CW-1:0][PW-1:0]   o_free_preg;
    logic                    o_squash;
    logic                    o_busy;
    logic [63:0]             o_epc;
    logic                    o_redirect_vld;
    logic [63:0]             o_redirect_pc;
    logic [4:0]              i_rat_ridx;
    logic [PW-1:0]           o_rat_rdata;
`ifdef ROB_COMMIT_PERF_COUNTER_EN
    logic [63:0]             o_instret;
    logic [31:0]             o_except_cnt;
`endif

    rob_commit dut (
        .clk               (clk),
        .rst               (rst),
        .i_commit_vld      (i_commit_vld),
        .i_commit_ldst     (i_commit_ldst),
        .i_commit_pdst     (i_commit_pdst),
        .i_commit_old_pdst (i_commit_old_pdst),
        .i_commit_rd_wen   (i_commit_rd_wen),
        .i_commit_except   (i_commit_except),
        .i_commit_pc       (i_commit_pc),
        .o_free_vld        (o_free_vld),
        .o_free_preg       (o_free_preg),
        .o_squash          (o_squash),
        .o_busy            (o_busy),
        .o_epc             (o_epc),
        .o_redirect_vld    (o_redirect_vld),
        .o_redirect_pc     (o_redirect_pc),
        .i_rat_ridx        (i_rat_ridx),
        .o_rat_rdata       (o_rat_rdata)
`ifdef ROB_COMMIT_PERF_COUNTER_EN
        ,
        .o_instret         (o_instret),
        .o_except_cnt      (o_except_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: committed RAT plus the outputs expected at the next check.
    logic [PW-1:0] m_rat [32];
    logic [CW-1:0] e_free_vld;
    logic [PW-1:0] e_free_preg [CW];
    logic [4:0]    e_ldst [CW];
    logic [PW-1:0] e_pdst [CW];
    logic          e_squash;
    logic [63:0]   e_epc;
    logic          e_busy;
    logic          e_redirect;
    logic [PW-1:0] e_rdata;
    int            age;       // cycles since the squash pulse, -1 when none pending
`ifdef ROB_COMMIT_PERF_COUNTER_EN
    logic [63:0]   e_instret;
    logic [31:0]   e_exc_cnt;
    int            ret_pending;
`endif

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance the model by the inputs currently driven.
    task automatic predict();
        logic stop;
        int   nret;
        if (rst) begin
            for (int a = 0; a < 32; a++) m_rat[a] = PW'(a);
            e_free_vld = '0;
            e_squash   = 1'b0;
            e_epc      = '0;
            e_busy     = 1'b0;
            e_redirect = 1'b0;
            age        = -1;
`ifdef ROB_COMMIT_PERF_COUNTER_EN
            e_instret   = '0;
            e_exc_cnt   = '0;
            ret_pending = 0;
`endif
        end else begin
            for (int s = 0; s < CW; s++) begin
                if (e_free_vld[s]) m_rat[e_ldst[s]] = e_pdst[s];
            end
`ifdef ROB_COMMIT_PERF_COUNTER_EN
            e_instret = e_instret + 64'(ret_pending);
            if (e_squash) e_exc_cnt = e_exc_cnt + 32'd1;
`endif
            e_free_vld = '0;
            e_squash   = 1'b0;
            stop       = (age >= 0 && age <= F);
            nret       = 0;
            for (int s = 0; s < CW; s++) begin
                if (!stop && i_commit_vld[s]) begin
                    if (i_commit_except[s]) begin
                        stop     = 1'b1;
                        e_squash = 1'b1;
                        e_epc    = i_commit_pc[s];
                    end else begin
                        nret++;
                        if (i_commit_rd_wen[s] && i_commit_ldst[s] != 5'd0) begin
                            e_free_vld[s]  = 1'b1;
                            e_free_preg[s] = i_commit_old_pdst[s];
                            e_ldst[s]      = i_commit_ldst[s];
                            e_pdst[s]      = i_commit_pdst[s];
                        end
                    end
                end else begin
                    stop = 1'b1;
                end
            end
`ifdef ROB_COMMIT_PERF_COUNTER_EN
            ret_pending = nret;
`endif
            if (e_squash)                 age = 0;
            else if (age >= 0 && age < F) age = age + 1;
            else                          age = -1;
            e_busy     = (age >= 1 && age <= F);
            e_redirect = (age == F);
        end
        e_rdata = m_rat[i_rat_ridx];
    endtask

    task automatic compare();
        for (int s = 0; s < CW; s++) begin
            chk($sformatf("free_vld[%0d]", s), 64'(o_free_vld[s]), 64'(e_free_vld[s]));
            if (e_free_vld[s]) chk($sformatf("free_preg[%0d]", s), 64'(o_free_preg[s]), 64'(e_free_preg[s]));
        end
        chk("squash", 64'(o_squash), 64'(e_squash));
        chk("busy", 64'(o_busy), 64'(e_busy));
        chk("redirect_vld", 64'(o_redirect_vld), 64'(e_redirect));
        if (e_redirect) chk("redirect_pc", o_redirect_pc, TV);
        chk("epc", o_epc, e_epc);
        chk("rat_rdata", 64'(o_rat_rdata), 64'(e_rdata));
`ifdef ROB_COMMIT_PERF_COUNTER_EN
        chk("instret", o_instret, e_instret);
        chk("except_cnt", 64'(o_except_cnt), 64'(e_exc_cnt));
`endif
    endtask

    task automatic cycle();
        predict();
        @(negedge clk);
        compare();
    endtask

    task automatic set_idle();
        i_commit_vld      = '0;
        i_commit_ldst     = '0;
        i_commit_pdst     = '0;
        i_commit_old_pdst = '0;
        i_commit_rd_wen   = '0;
        i_commit_except   = '0;
        i_commit_pc       = '0;
    endtask

    task automatic set_slot(input int s, input int ldst, input int pdst, input int old,
                            input logic wen, input logic exc, input logic [63:0] pc);
        i_commit_vld[s]      = 1'b1;
        i_commit_ldst[s]     = 5'(ldst);
        i_commit_pdst[s]     = PW'(pdst);
        i_commit_old_pdst[s] = PW'(old);
        i_commit_rd_wen[s]   = wen;
        i_commit_except[s]   = exc;
        i_commit_pc[s]       = pc;
    endtask

    initial begin
        rst = 1'b1;
        set_idle();
        i_rat_ridx = '0;
        cycle();
        cycle();
        chk("reset_busy", 64'(o_busy), 64'd0);
        rst = 1'b0;

        for (int r = 0; r < 32; r++) begin
            i_rat_ridx = 5'(r);
            cycle();
            chk("rat_identity", 64'(o_rat_rdata), 64'(r));
        end

        // Full group of four distinct writers.
        set_idle();
        for (int s = 0; s < 4; s++) set_slot(s, s + 1, 40 + s, s + 1, 1'b1, 1'b0, 64'h1000 + 64'(4 * s));
        cycle();
        chk("g1_free_vld", 64'(o_free_vld), 64'hf);
        for (int s = 0; s < 4; s++) chk("g1_free_preg", 64'(o_free_preg[s]), 64'(s + 1));
        set_idle();
        for (int r = 1; r <= 4; r++) begin
            i_rat_ridx = 5'(r);
            cycle();
            chk("g1_rat", 64'(o_rat_rdata), 64'(39 + r));
        end

        // Same ldst twice in one group.
        set_idle();
        set_slot(0, 5, 50, 5, 1'b1, 1'b0, 64'h1100);
        set_slot(1, 6, 60, 6, 1'b1, 1'b0, 64'h1104);
        set_slot(2, 5, 52, 50, 1'b1, 1'b0, 64'h1108);
        cycle();
        chk("dup_free_vld", 64'(o_free_vld), 64'h7);
        chk("dup_free0", 64'(o_free_preg[0]), 64'd5);
        chk("dup_free2", 64'(o_free_preg[2]), 64'd50);
        set_idle();
        i_rat_ridx = 5'd5;
        cycle();
        chk("dup_rat5", 64'(o_rat_rdata), 64'd52);

        // x0 destination and a non-writing slot.
        set_idle();
        set_slot(0, 0, 33, 34, 1'b1, 1'b0, 64'h1200);
        set_slot(1, 7, 35, 7, 1'b0, 1'b0, 64'h1204);
        cycle();
        chk("nowr_free_vld", 64'(o_free_vld), 64'h0);
        set_idle();
        i_rat_ridx = 5'd7;
        cycle();
        chk("nowr_rat7", 64'(o_rat_rdata), 64'd7);
        i_rat_ridx = 5'd0;
        cycle();
        chk("nowr_rat0", 64'(o_rat_rdata), 64'd0);

        // Exception on slot 1: slot 0 retires, squash, drain, redirect.
        set_idle();
        set_slot(0, 8, 44, 8, 1'b1, 1'b0, 64'h1000);
        set_slot(1, 9, 45, 9, 1'b1, 1'b1, 64'h1004);
        set_slot(2, 10, 46, 10, 1'b1, 1'b0, 64'h1008);
        cycle();
        chk("exc_free_vld", 64'(o_free_vld), 64'h1);
        chk("exc_free0", 64'(o_free_preg[0]), 64'd8);
        chk("exc_squash", 64'(o_squash), 64'd1);
        chk("exc_epc", o_epc, 64'h1004);
        set_idle();
        for (int a = 1; a <= 3; a++) begin
            cycle();
            chk("exc_busy", 64'(o_busy), 64'd1);
            chk("exc_redirect", 64'(o_redirect_vld), (a == 3) ? 64'd1 : 64'd0);
            if (a == 3) chk("exc_redirect_pc", o_redirect_pc, 64'h8000_0000);
        end
        i_rat_ridx = 5'd8;
        cycle();
        chk("post_busy", 64'(o_busy), 64'd0);
        chk("post_rat8", 64'(o_rat_rdata), 64'd44);
        i_rat_ridx = 5'd9;
        cycle();
        chk("post_rat9", 64'(o_rat_rdata), 64'd9);

        // Reset during the drain.
        set_idle();
        set_slot(0, 11, 47, 11, 1'b1, 1'b1, 64'h2000);
        cycle();
        chk("rf_squash", 64'(o_squash), 64'd1);
        chk("rf_epc", o_epc, 64'h2000);
        set_idle();
        cycle();
        rst = 1'b1;
        cycle();
        chk("rf_busy", 64'(o_busy), 64'd0);
        rst = 1'b0;
        i_rat_ridx = 5'd1;
        for (int c = 0; c < 4; c++) begin
            cycle();
            chk("rf_no_redirect", 64'(o_redirect_vld), 64'd0);
            chk("rf_rat1", 64'(o_rat_rdata), 64'd1);
        end

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            set_idle();
            rst = ($urandom_range(0, 299) == 0);
            if (!rst && !(age >= 0 && age <= F)) begin
                int nv;
                nv = $urandom_range(0, CW);
                for (int s = 0; s < nv; s++) begin
                    set_slot(s, $urandom_range(0, 7), $urandom_range(0, 63), $urandom_range(0, 63),
                             ($urandom_range(0, 4) != 0), ($urandom_range(0, 11) == 0),
                             {$urandom, $urandom});
                end
            end
            i_rat_ridx = 5'($urandom_range(0, 31));
            cycle();
        end
        rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
